// File: rtl/alu_op_selector.sv
// alu_op_selector: turns two raw, bouncing, active-low push-buttons into a
// registered operation code 0..OP_MAX for the ALU control input.
// Pipeline per button: two-flop synchroniser, stable-count debouncer and
// press-edge detector, feeding an up/down wrap-around counter.
// Optional feature macro: ALU_OP_AUTOREPEAT_EN. When it is defined, a held
// button auto-repeats after REPEAT_DELAY cycles and then every REPEAT_PERIOD
// cycles. Without it, a held button yields exactly one step.
module alu_op_selector #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int OP_MAX          = 9,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_inc_n,
   input  logic       btn_dec_n,
   output logic [3:0] op_code,
   output logic       op_step,
   output logic       btn_inc_db,
   output logic       btn_dec_db
);

   // Bit 0 of every per-button vector is the increment button, bit 1 is decrement.
   localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      OP_LAST = 4'(OP_MAX);

   logic [1:0]      sync_meta;
   logic [1:0]      sync_level;
   logic [1:0]      db_level;
   logic [1:0]      db_level_q;
   logic [DB_W-1:0] db_cnt [2];
   logic [1:0]      press_evt;
   logic            inc_req;
   logic            dec_req;

   // Two-flop synchroniser; idle level is high (released).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta  <= 2'b11;
         sync_level <= 2'b11;
      end else begin
         sync_meta  <= {btn_dec_n, btn_inc_n};
         sync_level <= sync_meta;
      end
   end

   // Debouncer: the level only follows after DEBOUNCE_CYCLES consecutive differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level  <= 2'b11;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_level[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_level[i] <= sync_level[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Delayed copy of the debounced levels so a press shows up as a one-cycle falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_level_q <= 2'b11;
      end else begin
         db_level_q <= db_level;
      end
   end

   assign press_evt  = db_level_q & ~db_level;
   assign btn_inc_db = db_level[0];
   assign btn_dec_db = db_level[1];

`ifdef ALU_OP_AUTOREPEAT_EN
   localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W       = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_active;
   logic             rpt_first_done;
   logic             one_held;
   logic             rpt_fire;

   // Repeating is only meaningful while exactly one button is held down.
   assign one_held = db_level[0] ^ db_level[1];
   assign rpt_fire = rpt_active && one_held && (press_evt == 2'b00) &&
                     (rpt_cnt == (rpt_first_done ? PERIOD_LAST : DELAY_LAST));

   // Repeat timer: armed by a lone press, first fire after the delay, then periodic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_cnt        <= '0;
         rpt_active     <= 1'b0;
         rpt_first_done <= 1'b0;
      end else if (!one_held) begin
         rpt_cnt        <= '0;
         rpt_active     <= 1'b0;
         rpt_first_done <= 1'b0;
      end else if (press_evt != 2'b00) begin
         rpt_cnt        <= '0;
         rpt_active     <= 1'b1;
         rpt_first_done <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt        <= '0;
         rpt_first_done <= 1'b1;
      end else if (rpt_active) begin
         rpt_cnt <= rpt_cnt + 1'b1;
      end
   end

   assign inc_req = press_evt[0] | (rpt_fire & ~db_level[0]);
   assign dec_req = press_evt[1] | (rpt_fire & ~db_level[1]);
`else
   logic unused_rpt_cfg;

   assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
   assign inc_req        = press_evt[0];
   assign dec_req        = press_evt[1];
`endif

   // Wrap-around operation counter; simultaneous inc and dec cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_code <= 4'd0;
         op_step <= 1'b0;
      end else begin
         op_step <= 1'b0;
         if (inc_req && !dec_req) begin
            op_code <= (op_code == OP_LAST) ? 4'd0 : op_code + 4'd1;
            op_step <= (OP_LAST != 4'd0);
         end else if (dec_req && !inc_req) begin
            op_code <= (op_code == 4'd0) ? OP_LAST : op_code - 4'd1;
            op_step <= (OP_LAST != 4'd0);
         end
      end
   end

endmodule

// File: tb/tb_alu_op_selector.sv
// tb_alu_op_selector: self-checking bench for alu_op_selector with
// DEBOUNCE_CYCLES=4 and OP_MAX=9. Expected op codes are pushed to a queue
// as each press is driven and popped whenever the DUT pulses op_step.
// Define ALU_OP_AUTOREPEAT_EN to also exercise the auto-repeat build.
module tb_alu_op_selector;

   localparam int DC  = 4;
   localparam int OPM = 9;
`ifdef ALU_OP_AUTOREPEAT_EN
   localparam int INC_HOLD = 10;
`else
   localparam int INC_HOLD = 20;
`endif

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       btn_inc_n = 1'b1;
   logic       btn_dec_n = 1'b1;
   logic [3:0] op_code;
   logic       op_step;
   logic       btn_inc_db;
   logic       btn_dec_db;

   int         errors     = 0;
   int         checks     = 0;
   int         steps      = 0;
   int         model_code = 0;
   logic [3:0] sb_q [$];
   logic [3:0] sb_exp;

   alu_op_selector #(
      .DEBOUNCE_CYCLES(DC),
      .OP_MAX(OPM),
      .REPEAT_DELAY(10),
      .REPEAT_PERIOD(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_inc_n(btn_inc_n),
      .btn_dec_n(btn_dec_n),
      .op_code(op_code),
      .op_step(op_step),
      .btn_inc_db(btn_inc_db),
      .btn_dec_db(btn_dec_db)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Scoreboard: every step pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && op_step === 1'b1) begin
         steps++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_step: unexpected step to op_code=%0d, none expected", op_code);
         end else begin
            sb_exp = sb_q.pop_front();
            if (op_code !== sb_exp) begin
               errors++;
               $display("[TB] FAIL sb_code: op_code=%0d, expected %0d", op_code, sb_exp);
            end
         end
      end
   end

   // Hard stop so a stuck run still terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_step(input bit inc);
      if (inc) model_code = (model_code == OPM) ? 0 : model_code + 1;
      else     model_code = (model_code == 0) ? OPM : model_code - 1;
      sb_q.push_back(4'(model_code));
   endtask

   task automatic press(input bit inc, input int hold);
      push_step(inc);
      if (inc) btn_inc_n = 1'b0;
      else     btn_dec_n = 1'b0;
      tick(hold);
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      tick(DC + 6);
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      checks++; if (op_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d want 0", op_code); end
      checks++; if (op_step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %0b want 0", op_step); end
      checks++; if (btn_inc_db !== 1'b1) begin errors++; $display("[TB] FAIL reset_inc_db: got %0b want 1", btn_inc_db); end
      checks++; if (btn_dec_db !== 1'b1) begin errors++; $display("[TB] FAIL reset_dec_db: got %0b want 1", btn_dec_db); end
   endtask

   task automatic test_inc_press();
      int s0;
      s0 = steps;
      push_step(1'b1);
      btn_inc_n = 1'b0;
      for (int e = 1; e <= INC_HOLD; e++) begin
         tick(1);
         if (e == DC + 1) begin
            checks++; if (btn_inc_db !== 1'b1) begin errors++; $display("[TB] FAIL inc_db_early: got %0b want 1 at edge %0d", btn_inc_db, e); end
         end
         if (e == DC + 2) begin
            checks++; if (btn_inc_db !== 1'b0) begin errors++; $display("[TB] FAIL inc_db_flip: got %0b want 0 at edge %0d", btn_inc_db, e); end
            checks++; if (op_code !== 4'd0) begin errors++; $display("[TB] FAIL inc_early: got %0d want 0 at edge %0d", op_code, e); end
         end
         if (e == DC + 3) begin
            checks++; if (op_code !== 4'd1) begin errors++; $display("[TB] FAIL inc_code: got %0d want 1 at edge %0d", op_code, e); end
            checks++; if (op_step !== 1'b1) begin errors++; $display("[TB] FAIL inc_step: got %0b want 1 at edge %0d", op_step, e); end
         end
         if (e == DC + 4) begin
            checks++; if (op_step !== 1'b0) begin errors++; $display("[TB] FAIL inc_step_len: got %0b want 0 at edge %0d", op_step, e); end
         end
      end
      checks++; if (op_code !== 4'd1) begin errors++; $display("[TB] FAIL inc_held: got %0d want 1", op_code); end
      btn_inc_n = 1'b1;
      tick(DC + 6);
      checks++; if (steps - s0 !== 1) begin errors++; $display("[TB] FAIL inc_count: got %0d steps want 1", steps - s0); end
      checks++; if (op_code !== 4'd1) begin errors++; $display("[TB] FAIL inc_release: got %0d want 1", op_code); end
   endtask

   task automatic test_wrap();
      int s0;
      s0 = steps;
      for (int i = 0; i < 8; i++) press(1'b1, 8);
      checks++; if (op_code !== 4'd9) begin errors++; $display("[TB] FAIL wrap_to_max: got %0d want 9", op_code); end
      press(1'b1, 8);
      checks++; if (op_code !== 4'd0) begin errors++; $display("[TB] FAIL wrap_inc: got %0d want 0", op_code); end
      press(1'b0, 8);
      checks++; if (op_code !== 4'd9) begin errors++; $display("[TB] FAIL wrap_dec: got %0d want 9", op_code); end
      checks++; if (steps - s0 !== 10) begin errors++; $display("[TB] FAIL wrap_count: got %0d steps want 10", steps - s0); end
   endtask

   task automatic test_bounce();
      int s0;
      bit db_moved;
      s0       = steps;
      db_moved = 1'b0;
      for (int c = 0; c < 30; c++) begin
         btn_inc_n = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
         if (btn_inc_db !== 1'b1) db_moved = 1'b1;
      end
      btn_inc_n = 1'b1;
      tick(DC + 6);
      checks++; if (db_moved !== 1'b0) begin errors++; $display("[TB] FAIL bounce_db: debounced level moved, got %0b want 0", db_moved); end
      checks++; if (op_code !== 4'(model_code)) begin errors++; $display("[TB] FAIL bounce_code: got %0d want %0d", op_code, model_code); end
      checks++; if (steps - s0 !== 0) begin errors++; $display("[TB] FAIL bounce_step: got %0d steps want 0", steps - s0); end
   endtask

   task automatic test_simultaneous();
      int s0;
      bit split;
      for (int i = 0; i < 4; i++) press(1'b0, 8);
      checks++; if (op_code !== 4'd5) begin errors++; $display("[TB] FAIL simul_setup: got %0d want 5", op_code); end
      s0        = steps;
      split     = 1'b0;
      btn_inc_n = 1'b0;
      btn_dec_n = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick(1);
         if (btn_inc_db !== btn_dec_db) split = 1'b1;
         if (e == DC + 2) begin
            checks++; if ({btn_inc_db, btn_dec_db} !== 2'b00) begin errors++; $display("[TB] FAIL simul_db: got %b want 00", {btn_inc_db, btn_dec_db}); end
         end
      end
      btn_inc_n = 1'b1;
      btn_dec_n = 1'b1;
      tick(DC + 6);
      checks++; if (split !== 1'b0) begin errors++; $display("[TB] FAIL simul_edge: debounced levels split, got %0b want 0", split); end
      checks++; if (op_code !== 4'd5) begin errors++; $display("[TB] FAIL simul_code: got %0d want 5", op_code); end
      checks++; if (steps - s0 !== 0) begin errors++; $display("[TB] FAIL simul_step: got %0d steps want 0", steps - s0); end
   endtask

   task automatic test_reset_mid_debounce();
      int s0;
      s0        = steps;
      btn_inc_n = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      checks++; if (op_code !== 4'd0) begin errors++; $display("[TB] FAIL rst_async: got %0d want 0", op_code); end
      btn_inc_n = 1'b1;
      tick(2);
      rst_n      = 1'b1;
      model_code = 0;
      tick(DC + 8);
      checks++; if (op_code !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_code: got %0d want 0", op_code); end
      checks++; if (steps - s0 !== 0) begin errors++; $display("[TB] FAIL rst_mid_step: got %0d steps want 0", steps - s0); end
      checks++; if ({btn_inc_db, btn_dec_db} !== 2'b11) begin errors++; $display("[TB] FAIL rst_mid_db: got %b want 11", {btn_inc_db, btn_dec_db}); end
   endtask

   task automatic test_back_to_back();
      press(1'b1, 6);
      press(1'b1, 6);
      press(1'b0, 6);
      checks++; if (op_code !== 4'd1) begin errors++; $display("[TB] FAIL b2b_code: got %0d want 1", op_code); end
   endtask

`ifdef ALU_OP_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int s0;
      bit want;
      s0 = steps;
      for (int i = 0; i < 6; i++) push_step(1'b1);
      btn_inc_n = 1'b0;
      for (int e = 1; e <= 45; e++) begin
         tick(1);
         if (e == 33) btn_inc_n = 1'b1;
         want = (e == DC + 3) || (e >= 17 && e <= 37 && (e - 17) % 5 == 0);
         checks++; if (op_step !== want) begin errors++; $display("[TB] FAIL rpt_step: got %0b want %0b at edge %0d", op_step, want, e); end
      end
      checks++; if (steps - s0 !== 6) begin errors++; $display("[TB] FAIL rpt_count: got %0d steps want 6", steps - s0); end
      checks++; if (op_code !== 4'(model_code)) begin errors++; $display("[TB] FAIL rpt_code: got %0d want %0d", op_code, model_code); end
   endtask
`endif

   // Scenario sequence followed by the end-of-run scoreboard drain check.
   initial begin
      $display("[TB] starting alu_op_selector bench");
      test_reset();
      test_inc_press();
      test_wrap();
      test_bounce();
      test_simultaneous();
      test_reset_mid_debounce();
      test_back_to_back();
`ifdef ALU_OP_AUTOREPEAT_EN
      test_autorepeat();
`endif
      tick(4);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_drain: %0d expected steps never seen, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_op_selector.md
# alu_op_selector

Upstream control stage for the 4-bit ALU: converts two raw, bouncing, active-low push-buttons into a registered operation code in the range 0..OP_MAX that drives the ALU `control` input and the operation 7-segment display. It replaces asynchronous dual-edge button clocking with a single-clock design: a synchroniser, a debouncer, press-edge detection and an up/down wrap-around counter.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); minimum 2.
- `OP_MAX`, default 9: highest operation code; the counter wraps between 0 and OP_MAX.
- `REPEAT_DELAY`, default 25000000: hold time in cycles before the first auto-repeat step (auto-repeat build only).
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent auto-repeat steps (auto-repeat build only).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_inc_n`  in  1  raw increment button, low = pressed, asynchronous to `clk`.
- `btn_dec_n`  in  1  raw decrement button, low = pressed, asynchronous to `clk`.
- `op_code`  out  4  registered operation code, 0..OP_MAX.
- `op_step`  out  1  one-cycle pulse, high in the cycle `op_code` takes a new value.
- `btn_inc_db`  out  1  debounced increment level, low = pressed (bench and LED visibility).
- `btn_dec_db`  out  1  debounced decrement level, low = pressed.

## Operation
- Reset (`rst_n` low, asynchronous): `op_code`=0, `op_step`=0, `btn_inc_db`=`btn_dec_db`=1, synchroniser flops=1, debounce and repeat counters=0. Reset asserted mid-debounce or mid-hold discards all progress.
- Synchroniser: two flops per button; only the second-stage output feeds the debouncer.
- Debouncer, per button: the counter increments each cycle the synchronised level differs from the debounced level and clears to 0 on any cycle they match. When the counter is at DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips on that edge and the counter clears.
- Press event: a 1→0 transition of a debounced level. Release events (0→1) have no effect on `op_code`.
- Counter:
  - Increment event alone: `op_code` = (`op_code`==OP_MAX) ? 0 : `op_code`+1.
  - Decrement event alone: `op_code` = (`op_code`==0) ? OP_MAX : `op_code`-1.
  - Both events in the same cycle: no change, no `op_step`.
- `op_step` is registered and asserts only when `op_code` actually changes.
- Widths: `op_code` is 4 bits; OP_MAX ≤ 15. Counter widths derive from the parameters via $clog2.

## Timing
- Edge 1 = first rising edge that samples a raw button low. Second synchroniser stage updates at edge 2; debounced level flips at edge 2+DEBOUNCE_CYCLES; `op_code` and `op_step` update at edge 3+DEBOUNCE_CYCLES.
- A glitch or bounce shorter than DEBOUNCE_CYCLES synchronised cycles never changes a debounced level.
- Maximum rate is one step per press. In auto-repeat builds the maximum rate is one step per REPEAT_PERIOD.
- No combinational path from inputs to outputs.

## Configuration
- `ALU_OP_AUTOREPEAT_EN` defined: while exactly one debounced button is held, a repeat counter starts at the press event.
  - REPEAT_DELAY cycles after the press event, the block generates one step in the held direction.
  - After that, it generates one step every REPEAT_PERIOD cycles until release.
  - A release, a press of the other button, or reset clears the repeat counter. No repeat steps occur while both buttons are held.
- `ALU_OP_AUTOREPEAT_EN` undefined: no repeat logic is present, REPEAT_* are ignored, and a held button yields exactly one step.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, OP_MAX=9.
- Reset: hold `rst_n` low, then release → `op_code`=0, `op_step`=0, both `_db` outputs=1.
- Clean inc press held for 20 cycles from `op_code`=0 → `op_code`=1 at edge 7, `op_step` high for exactly that one cycle, no further change while held.
- Wrap: 9 + inc → 0; 0 + dec → 9; each step gives a single `op_step` pulse.
- Bounce: `btn_inc_n` toggling low/high every 2 cycles for 30 cycles, then high → `op_code` unchanged, `op_step` never asserted.
- Simultaneous: both raw buttons fall on the same edge with `op_code`=5 → both `_db` outputs go to 0 on the same edge, `op_code` stays 5, no `op_step`.
- Reset mid-debounce: press inc, assert `rst_n` at cycle 4 → `op_code`=0 and nothing pending. Auto-repeat build with REPEAT_DELAY=10, REPEAT_PERIOD=5, inc held 30 cycles past the press event → steps at +0, +10, +15, +20, +25, +30.
